// File: rtl/vram_queue_pkg.sv
// rtl/vram_queue_pkg.sv - shared types, constants and helpers for the VRAM write queue
package vram_queue_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2
    } drain_state_e;

    localparam int DATA_W = 8;

    // Queue entry holds {address, data}
    function automatic int entry_w(input int addr_w);
        return addr_w + DATA_W;
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_m.sv
// rtl/sync_fifo_m.sv - single-clock FIFO with same-cycle push/pop and next-head peek
module sync_fifo_m
    import vram_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 20,
    parameter int PTR_W = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] rdata_next,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0]   CNT_DEPTH = DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   CNT_ONE   = 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full       = (count_q == CNT_DEPTH);
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign rdata      = mem_q[rd_ptr_q];
    assign rdata_next = mem_q[rd_ptr_q + PTR_ONE];

    // A push into a full FIFO is only accepted when the head leaves in the same cycle
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop) count_d = count_q + CNT_ONE;
        else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
    end

    // Pointer/count state; storage itself needs no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vram_write_queue.sv
// rtl/vram_write_queue.sv - posted CPU-to-VRAM write buffer drained only during blanking
module vram_write_queue
    import vram_queue_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 12
) (
    input  logic              clk_12_5875,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [7:0]        cpu_data,
    input  logic              write_enable,
    input  logic              SELECT_vram,
    input  logic              gpu_busy,
    input  logic              clr_overflow,
    output logic [ADDR_W-1:0] vram_address,
    output logic [7:0]        vram_wdata,
    output logic              vram_we,
    output logic              queue_empty,
    output logic              queue_full,
    output logic              overflow
);

    localparam int             ENTRY_W = entry_w(ADDR_W);
    localparam int             PTR_W   = clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE = 1;

    logic                req, req_q, req_d, enq;
    logic                overflow_q, overflow_d, drop;
    logic                pop, more;
    logic [ENTRY_W-1:0]  new_entry, head, head_next, next_load;
    logic [PTR_W:0]      count;
    drain_state_e        state_q, state_d;
    logic [ADDR_W-1:0]   vram_address_q, vram_address_d;
    logic [7:0]          vram_wdata_q, vram_wdata_d;

    assign req       = write_enable & SELECT_vram;
    assign enq       = req & ~req_q;
    assign new_entry = {cpu_address, cpu_data};

    sync_fifo_m #(.DEPTH(DEPTH), .WIDTH(ENTRY_W), .PTR_W(PTR_W)) u_fifo (
        .clk        (clk_12_5875),
        .rst        (rst),
        .push       (enq),
        .wdata      (new_entry),
        .pop        (pop),
        .rdata      (head),
        .rdata_next (head_next),
        .count      (count),
        .full       (queue_full),
        .empty      (queue_empty)
    );

    // Edge detect and sticky overflow; a drop in the same cycle beats the clear
    always_comb begin
        req_d      = req;
        drop       = enq & queue_full & ~pop;
        overflow_d = overflow_q;
        if (drop) overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
    end

    // Drain FSM: entries that remain after a pop may be the one arriving this cycle
    always_comb begin
        state_d        = state_q;
        vram_address_d = vram_address_q;
        vram_wdata_d   = vram_wdata_q;
        vram_we        = 1'b0;
        pop            = 1'b0;
        more           = (count != CNT_ONE) | enq;
        next_load      = (count == CNT_ONE) ? new_entry : head_next;
        case (state_q)
            IDLE: begin
                if (!queue_empty && !gpu_busy) begin
                    state_d                        = SETUP;
                    {vram_address_d, vram_wdata_d} = head;
                end
            end
            SETUP: begin
                state_d = gpu_busy ? IDLE : STROBE;
            end
            STROBE: begin
                vram_we = 1'b1;
                pop     = 1'b1;
                if (more && !gpu_busy) begin
                    state_d                        = SETUP;
                    {vram_address_d, vram_wdata_d} = next_load;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk_12_5875) begin
        if (rst) begin
            req_q          <= 1'b0;
            overflow_q     <= 1'b0;
            state_q        <= IDLE;
            vram_address_q <= '0;
            vram_wdata_q   <= '0;
        end else begin
            req_q          <= req_d;
            overflow_q     <= overflow_d;
            state_q        <= state_d;
            vram_address_q <= vram_address_d;
            vram_wdata_q   <= vram_wdata_d;
        end
    end

    assign vram_address = vram_address_q;
    assign vram_wdata   = vram_wdata_q;
    assign overflow     = overflow_q;

endmodule
